// File: rtl/stream_src_rv.sv
// Programmable arithmetic token source on a valid/ready channel.
// Emits base, base+stride, ... for count tokens, then pulses done.
module stream_src_rv #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   start,
   input  logic [DATA_WIDTH-1:0]  base,
   input  logic [DATA_WIDTH-1:0]  stride,
   input  logic [COUNT_WIDTH-1:0] count,
   output logic                   busy,
   output logic                   done,
   output logic [DATA_WIDTH-1:0]  dout,
   output logic                   dout_v,
   input  logic                   dout_r
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [DATA_WIDTH-1:0]  val;
   logic [DATA_WIDTH-1:0]  step;
   logic [COUNT_WIDTH-1:0] remaining;
   logic                   xfer;
   logic                   last;

   assign xfer = enable && (state == RUN) && dout_r;
   assign last = (remaining == COUNT_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (enable) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (count != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (dout_r && last) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Every output is a decode of the state register or a register itself.
   always_comb begin
      busy   = (state == RUN);
      done   = (state == DONE);
      dout_v = (state == RUN);
      dout   = val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         val       <= '0;
         step      <= '0;
         remaining <= '0;
      end else if (enable) begin
         if (state == IDLE && start && count != '0) begin
            val       <= base;
            step      <= stride;
            remaining <= count;
         end else if (xfer) begin
            if (last) begin
               remaining <= '0;
            end else begin
               val       <= val + step;
               remaining <= remaining - COUNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_src_rv.sv
// Directed self-checking bench for stream_src_rv.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_stream_src_rv;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        start;
   logic [31:0] base;
   logic [31:0] stride;
   logic [15:0] count;
   logic        busy;
   logic        done;
   logic [31:0] dout;
   logic        dout_v;
   logic        dout_r;

   int checks = 0;
   int errors = 0;

   stream_src_rv #(
      .DATA_WIDTH (32),
      .COUNT_WIDTH(16)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .enable(enable),
      .start (start),
      .base  (base),
      .stride(stride),
      .count (count),
      .busy  (busy),
      .done  (done),
      .dout  (dout),
      .dout_v(dout_v),
      .dout_r(dout_r)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [31:0] b, input logic [31:0] s,
                         input logic [15:0] c);
      base   = b;
      stride = s;
      count  = c;
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   // Expect a valid token with the given value, then let it transfer.
   task automatic tok(input string tag, input logic [31:0] exp);
      chk({tag, "_v"}, 64'(dout_v), 64'd1);
      chk(tag, 64'(dout), 64'(exp));
      step();
   endtask

   task automatic fin(input string tag);
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_dv"}, 64'(dout_v), 64'd0);
      step();
      chk({tag, "_done0"}, 64'(done), 64'd0);
   endtask

   initial begin
      rst    = 1'b1;
      enable = 1'b1;
      start  = 1'b0;
      base   = '0;
      stride = '0;
      count  = '0;
      dout_r = 1'b1;
      step();
      step();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dv", 64'(dout_v), 64'd0);
      chk("rst_dout", 64'(dout), 64'd0);
      rst = 1'b0;
      step();

      // basic run
      launch(32'd10, 32'd3, 16'd4);
      for (int i = 0; i < 4; i++) begin
         chk("basic_busy", 64'(busy), 64'd1);
         tok("basic", 32'd10 + 32'(3 * i));
      end
      fin("basic");

      // backpressure: dout_r 1,0,0,1,0,1
      begin
         logic [5:0]  rdy;
         logic [31:0] exp [6];
         rdy = 6'b101001;
         exp = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2};
         launch(32'd0, 32'd1, 16'd3);
         for (int i = 0; i < 6; i++) begin
            dout_r = rdy[i];
            chk("bp_v", 64'(dout_v), 64'd1);
            chk("bp_dout", 64'(dout), 64'(exp[i]));
            step();
         end
         dout_r = 1'b1;
         fin("bp");
      end

      // wrap upward
      launch(32'hFFFF_FFFE, 32'd1, 16'd3);
      tok("wrap0", 32'hFFFF_FFFE);
      tok("wrap1", 32'hFFFF_FFFF);
      tok("wrap2", 32'h0000_0000);
      fin("wrap");

      // negative stride
      launch(32'd1, 32'hFFFF_FFFF, 16'd3);
      tok("neg0", 32'd1);
      tok("neg1", 32'd0);
      tok("neg2", 32'hFFFF_FFFF);
      fin("neg");

      // enable stall with a start pulse that must not be queued
      launch(32'd100, 32'd5, 16'd4);
      tok("stl0", 32'd100);
      enable = 1'b0;
      start  = 1'b1;
      base   = 32'd7;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stl_v", 64'(dout_v), 64'd1);
         chk("stl_dout", 64'(dout), 64'd105);
         chk("stl_busy", 64'(busy), 64'd1);
      end
      enable = 1'b1;
      start  = 1'b0;
      tok("stl1", 32'd105);
      tok("stl2", 32'd110);
      tok("stl3", 32'd115);
      fin("stl");
      chk("stl_idle_v", 64'(dout_v), 64'd0);
      chk("stl_idle_busy", 64'(busy), 64'd0);

      // zero count, done held across disabled cycles
      launch(32'd9, 32'd1, 16'd0);
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_v", 64'(dout_v), 64'd0);
      enable = 1'b0;
      step();
      step();
      chk("zero_hold", 64'(done), 64'd1);
      enable = 1'b1;
      step();
      chk("zero_clr", 64'(done), 64'd0);
      chk("zero_v2", 64'(dout_v), 64'd0);

      // start during RUN ignored
      launch(32'd20, 32'd2, 16'd3);
      start  = 1'b1;
      base   = 32'd999;
      stride = 32'd50;
      count  = 16'd7;
      tok("ign0", 32'd20);
      tok("ign1", 32'd22);
      tok("ign2", 32'd24);
      start = 1'b0;
      fin("ign");

      // reset mid-run, then a fresh sequence
      launch(32'd50, 32'd1, 16'd5);
      tok("mr0", 32'd50);
      tok("mr1", 32'd51);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_v", 64'(dout_v), 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_done", 64'(done), 64'd0);
      chk("mr_dout", 64'(dout), 64'd0);
      step();
      chk("mr_done2", 64'(done), 64'd0);
      launch(32'd3, 32'd4, 16'd2);
      tok("fr0", 32'd3);
      tok("fr1", 32'd7);
      fin("fr");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
